order_matcher: RTL



---
 rtl/order_matcher_pkg.sv | 36 +++
 rtl/order_matcher_if.sv | 27 ++
 rtl/order_matcher_book_level.sv | 62 ++++++
 rtl/order_matcher.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/order_matcher_pkg.sv
// Shared types and constants for the top-of-book order matcher.
package order_matcher_pkg;

    localparam int PRICE_W = 8;
    localparam int QTY_W   = 8;

    // An empty ask parks at the highest price and an empty bid at the lowest,
    // so an empty level can never look like a crossing price.
    localparam logic [PRICE_W-1:0] PRICE_EMPTY_ASK = '1;
    localparam logic [PRICE_W-1:0] PRICE_EMPTY_BID = '0;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        IDLE = 2'd1,
        EVAL = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        LVL_HOLD    = 3'd0,
        LVL_REPLACE = 3'd1,
        LVL_ADD     = 3'd2,
        LVL_DEC     = 3'd3,
        LVL_CLEAR   = 3'd4
    } lvl_op_t;

    function automatic logic [QTY_W-1:0] sat_add(input logic [QTY_W-1:0] a,
                                                 input logic [QTY_W-1:0] b);
        logic [QTY_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[QTY_W] ? {QTY_W{1'b1}} : sum[QTY_W-1:0];
    endfunction

endpackage

// File: rtl/order_matcher_if.sv
// Order-entry handshake and match/book output bundle of the order matcher.
interface order_matcher_if;
    import order_matcher_pkg::*;

    logic               order_valid;
    logic               order_ready;
    logic               order_side;
    logic [PRICE_W-1:0] order_price;
    logic [QTY_W-1:0]   order_qty;

    logic               match_signal;
    logic [PRICE_W-1:0] buy_price;
    logic [PRICE_W-1:0] sell_price;
    logic [PRICE_W-1:0] trade_price;
    logic [QTY_W-1:0]   trade_qty;

    modport master (
        output order_valid, order_side, order_price, order_qty,
        input  order_ready, match_signal, buy_price, sell_price, trade_price, trade_qty
    );

    modport slave (
        input  order_valid, order_side, order_price, order_qty,
        output order_ready, match_signal, buy_price, sell_price, trade_price, trade_qty
    );

endinterface

// File: rtl/order_matcher_book_level.sv
// One resting price level (price + quantity) for one side of the book.
// EMPTY_PRICE is the sentinel shown while the level holds nothing.
module book_level
    import order_matcher_pkg::*;
#(
    parameter logic [PRICE_W-1:0] EMPTY_PRICE = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  lvl_op_t            op_i,
    input  logic [PRICE_W-1:0] price_i,
    input  logic [QTY_W-1:0]   qty_i,
    output logic [PRICE_W-1:0] price_o,
    output logic [QTY_W-1:0]   qty_o,
    output logic               empty_o
);

    logic [PRICE_W-1:0] price_q, price_d;
    logic [QTY_W-1:0]   qty_q, qty_d;

    // Next level contents for the requested operation.
    always_comb begin
        price_d = price_q;
        qty_d   = qty_q;
        case (op_i)
            LVL_REPLACE: begin
                price_d = price_i;
                qty_d   = qty_i;
            end
            LVL_ADD: qty_d = sat_add(qty_q, qty_i);
            LVL_DEC: begin
                if (qty_i >= qty_q) begin
                    price_d = EMPTY_PRICE;
                    qty_d   = '0;
                end else begin
                    qty_d = qty_q - qty_i;
                end
            end
            LVL_CLEAR: begin
                price_d = EMPTY_PRICE;
                qty_d   = '0;
            end
            default: ;
        endcase
    end

    // Level storage; reset leaves the side empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            price_q <= EMPTY_PRICE;
            qty_q   <= '0;
        end else begin
            price_q <= price_d;
            qty_q   <= qty_d;
        end
    end

    assign price_o = price_q;
    assign qty_o   = qty_q;
    assign empty_o = (price_q == EMPTY_PRICE);

endmodule

// File: rtl/order_matcher.sv
// Top-of-book order matcher: one bid level, one ask level, one match per order.
// Optional statistics counters are built when ORDER_MATCHER_STATS_EN is defined.
//
// state | meaning
// OFF   | session closed, orders refused, book_clear honoured
// IDLE  | session open, order_ready high
// EVAL  | latched order evaluated against the book, results registered
module order_matcher
    import order_matcher_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           session_start,
    input  logic           session_halt,
    input  logic           book_clear,
    order_matcher_if.slave bus,
    output logic           enable_count,
    output logic [15:0]    trade_count,
    output logic [15:0]    reject_count
);

    state_t             state_q;
    logic               ready_q, enable_q, halt_pend_q;
    logic               ord_side_q;
    logic [PRICE_W-1:0] ord_price_q;
    logic [QTY_W-1:0]   ord_qty_q;
    logic               match_q;
    logic [PRICE_W-1:0] cross_buy_q, cross_sell_q, trade_price_q;
    logic [QTY_W-1:0]   trade_qty_q;

    logic [PRICE_W-1:0] bid_price, ask_price, rest_price;
    logic [QTY_W-1:0]   bid_qty, ask_qty, rest_qty, fill, residual;
    logic               bid_empty, ask_empty;
    logic               invalid, crosses, better, equal, own_empty;
    lvl_op_t            bid_op, ask_op;
    logic [QTY_W-1:0]   bid_op_qty, ask_op_qty;

    book_level #(.EMPTY_PRICE(PRICE_EMPTY_BID)) u_bid (
        .clk     (clk),
        .rst_n   (reset_n),
        .op_i    (bid_op),
        .price_i (ord_price_q),
        .qty_i   (bid_op_qty),
        .price_o (bid_price),
        .qty_o   (bid_qty),
        .empty_o (bid_empty)
    );

    book_level #(.EMPTY_PRICE(PRICE_EMPTY_ASK)) u_ask (
        .clk     (clk),
        .rst_n   (reset_n),
        .op_i    (ask_op),
        .price_i (ord_price_q),
        .qty_i   (ask_op_qty),
        .price_o (ask_price),
        .qty_o   (ask_qty),
        .empty_o (ask_empty)
    );

    // Match the latched order against the opposite level and decide where any residual rests.
    always_comb begin
        bid_op     = LVL_HOLD;
        ask_op     = LVL_HOLD;
        bid_op_qty = '0;
        ask_op_qty = '0;
        invalid    = (ord_price_q == PRICE_EMPTY_BID) || (ord_price_q == PRICE_EMPTY_ASK) ||
                     (ord_qty_q == '0);
        if (ord_side_q == SIDE_BUY) begin
            crosses    = !ask_empty && (ord_price_q >= ask_price);
            rest_price = ask_price;
            rest_qty   = ask_qty;
            own_empty  = bid_empty;
            better     = ord_price_q > bid_price;
            equal      = ord_price_q == bid_price;
        end else begin
            crosses    = !bid_empty && (ord_price_q <= bid_price);
            rest_price = bid_price;
            rest_qty   = bid_qty;
            own_empty  = ask_empty;
            better     = ord_price_q < ask_price;
            equal      = ord_price_q == ask_price;
        end
        crosses  = crosses && !invalid;
        fill     = crosses ? ((ord_qty_q < rest_qty) ? ord_qty_q : rest_qty) : '0;
        residual = ord_qty_q - fill;

        if (state_q == OFF && book_clear) begin
            bid_op = LVL_CLEAR;
            ask_op = LVL_CLEAR;
        end else if (state_q == EVAL && !invalid) begin
            if (crosses) begin
                if (ord_side_q == SIDE_BUY) begin
                    ask_op     = LVL_DEC;
                    ask_op_qty = fill;
                end else begin
                    bid_op     = LVL_DEC;
                    bid_op_qty = fill;
                end
            end
            if (residual != '0 && (own_empty || better || equal)) begin
                if (ord_side_q == SIDE_BUY) begin
                    bid_op     = (own_empty || better) ? LVL_REPLACE : LVL_ADD;
                    bid_op_qty = residual;
                end else begin
                    ask_op     = (own_empty || better) ? LVL_REPLACE : LVL_ADD;
                    ask_op_qty = residual;
                end
            end
        end
    end

    // Session FSM with order latch and registered match outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= OFF;
            ready_q       <= 1'b0;
            enable_q      <= 1'b0;
            halt_pend_q   <= 1'b0;
            ord_side_q    <= SIDE_BUY;
            ord_price_q   <= '0;
            ord_qty_q     <= '0;
            match_q       <= 1'b0;
            cross_buy_q   <= PRICE_EMPTY_BID;
            cross_sell_q  <= PRICE_EMPTY_ASK;
            trade_price_q <= '0;
            trade_qty_q   <= '0;
        end else begin
            match_q <= 1'b0;
            case (state_q)
                OFF: begin
                    if (session_start && !session_halt) begin
                        state_q  <= IDLE;
                        ready_q  <= 1'b1;
                        enable_q <= 1'b1;
                    end
                end
                IDLE: begin
                    // An order offered alongside a halt was already handshaken,
                    // so it is evaluated and the halt is taken right after.
                    if (bus.order_valid) begin
                        state_q     <= EVAL;
                        ready_q     <= 1'b0;
                        halt_pend_q <= session_halt;
                        ord_side_q  <= bus.order_side;
                        ord_price_q <= bus.order_price;
                        ord_qty_q   <= bus.order_qty;
                    end else if (session_halt) begin
                        state_q  <= OFF;
                        ready_q  <= 1'b0;
                        enable_q <= 1'b0;
                    end
                end
                EVAL: begin
                    match_q     <= crosses;
                    halt_pend_q <= 1'b0;
                    if (crosses) begin
                        trade_price_q <= rest_price;
                        trade_qty_q   <= fill;
                        cross_buy_q   <= (ord_side_q == SIDE_BUY) ? ord_price_q : rest_price;
                        cross_sell_q  <= (ord_side_q == SIDE_BUY) ? rest_price : ord_price_q;
                    end
                    if (session_halt || halt_pend_q) begin
                        state_q  <= OFF;
                        ready_q  <= 1'b0;
                        enable_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= OFF;
                    ready_q  <= 1'b0;
                    enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.order_ready  = ready_q;
    assign bus.match_signal = match_q;
    assign bus.buy_price    = match_q ? cross_buy_q : bid_price;
    assign bus.sell_price   = match_q ? cross_sell_q : ask_price;
    assign bus.trade_price  = trade_price_q;
    assign bus.trade_qty    = trade_qty_q;
    assign enable_count     = enable_q;

`ifdef ORDER_MATCHER_STATS_EN
    logic [15:0] trade_cnt_q, reject_cnt_q;
    logic        reject_now;

    // An order is rejected when invalid or when its residual finds no place on its side.
    assign reject_now = (state_q == EVAL) &&
                        (invalid || (residual != '0 &&
                         (((ord_side_q == SIDE_BUY) ? bid_op : ask_op) == LVL_HOLD)));

    // Wrap-around trade and reject statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trade_cnt_q  <= '0;
            reject_cnt_q <= '0;
        end else begin
            if (state_q == EVAL && crosses) trade_cnt_q <= trade_cnt_q + 16'd1;
            if (reject_now) reject_cnt_q <= reject_cnt_q + 16'd1;
        end
    end

    assign trade_count  = trade_cnt_q;
    assign reject_count = reject_cnt_q;
`else
    assign trade_count  = '0;
    assign reject_count = '0;
`endif

endmodule
